// File: rtl/brightness_filter.sv
// -----------------------------------------------------------------------------
// brightness_filter
//
// Per-pixel brightness adjuster for the RGB444 video path. One pixel and one
// level code are accepted on every rising clock edge. The same signed offset,
// selected by the level code, is added to each 4-bit colour channel on its
// own. Each channel result saturates to the range 0..15. The adjusted pixel is
// registered, so the latency is exactly one cycle.
//
// Ports:
//   clk        in   1   system clock; all logic runs on the rising edge
//   rst_n      in   1   synchronous reset, active-low; clears data_out
//   data_in    in  12   input pixel {R[11:8], G[7:4], B[3:0]}
//   freq_flag  in   3   brightness level code, sampled with data_in
//   data_out   out 12   adjusted pixel, same packing as data_in
// -----------------------------------------------------------------------------
module brightness_filter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] data_in,
    input  logic [2:0]  freq_flag,
    output logic [11:0] data_out
);

    // Level code to signed channel offset. All eight codes are defined, so no
    // input can produce X.
    function automatic logic signed [4:0] level_offset(input logic [2:0] code);
        case (code)
            3'd0:    return 5'sd0;
            3'd1:    return 5'sd1;
            3'd2:    return 5'sd2;
            3'd3:    return 5'sd4;
            3'd4:    return 5'sd8;
            3'd5:    return -5'sd2;
            3'd6:    return -5'sd4;
            default: return -5'sd8;
        endcase
    endfunction

    // Adds a signed offset to one unsigned 4-bit channel and clamps the result
    // to 0..15. The sum uses 6 bits so that 15 + 8 and 0 - 8 cannot wrap.
    function automatic logic [3:0] sat_add(input logic [3:0]        chan,
                                           input logic signed [4:0] offs);
        logic signed [5:0] sum;
        sum = $signed({2'b00, chan}) + $signed({offs[4], offs});
        if (sum > 6'sd15)
            return 4'hF;
        else if (sum < 6'sd0)
            return 4'h0;
        else
            return sum[3:0];
    endfunction

    logic signed [4:0] offs_p0;
    logic [11:0]       data_p0;

    // Stage p0: combinational per-channel adjust of the current input
    always_comb begin
        offs_p0 = level_offset(freq_flag);
        data_p0 = {sat_add(data_in[11:8], offs_p0),
                   sat_add(data_in[7:4],  offs_p0),
                   sat_add(data_in[3:0],  offs_p0)};
    end

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (!rst_n)
            data_out <= 12'h000;
        else
            data_out <= data_p0;
    end

endmodule

// File: tb/tb_brightness_filter.sv
// -----------------------------------------------------------------------------
// tb_brightness_filter
//
// Self-checking bench for brightness_filter. Stimulus is driven on the falling
// edge. Each driven pixel pushes its expected result into a scoreboard queue.
// The result is popped and compared 1 time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_brightness_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] data_in;
    logic [2:0]  freq_flag;
    logic [11:0] data_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    brightness_filter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .freq_flag (freq_flag),
        .data_out  (data_out)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h, expected %03h", tag, got, exp);
        end
    endtask

    // Reference model: integer arithmetic with an independent offset table.
    function automatic logic [11:0] model(input logic [11:0] pix, input logic [2:0] code);
        int offs_tbl[8] = '{0, 1, 2, 4, 8, -2, -4, -8};
        logic [11:0] r;
        int v;
        for (int c = 0; c < 3; c++) begin
            v = int'(pix[c*4 +: 4]) + offs_tbl[code];
            if (v > 15) v = 15;
            if (v < 0)  v = 0;
            r[c*4 +: 4] = 4'(v);
        end
        return r;
    endfunction

    // Drive one cycle of stimulus and queue the result required after the edge.
    task automatic drive(input string tag, input logic rst_v, input logic [11:0] pix,
                         input logic [2:0] code, input logic [11:0] exp);
        @(negedge clk);
        rst_n     = rst_v;
        data_in   = pix;
        freq_flag = code;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // Scoreboard compare, away from the active edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), data_out, exp_q.pop_front());
        end
    end

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] pix;
        logic [2:0]  code;

        rst_n     = 1'b0;
        data_in   = 12'hFFF;
        freq_flag = 3'd4;

        // Reset held for two edges with saturating input present
        drive("reset0", 1'b0, 12'hFFF, 3'd4, 12'h000);
        drive("reset1", 1'b0, 12'hFFF, 3'd4, 12'h000);
        drive("release", 1'b1, 12'hFFF, 3'd4, 12'hFFF);

        // Pass-through with latency: output holds until the capturing edge
        drive("pass_15d", 1'b1, 12'h15D, 3'd0, 12'h15D);
        #1;
        check("hold_before_edge", data_out, 12'hFFF);

        drive("up1_367", 1'b1, 12'h367, 3'd1, 12'h478);
        drive("up2_786", 1'b1, 12'h786, 3'd2, 12'h9A8);
        drive("up4_123", 1'b1, 12'h123, 3'd3, 12'h567);
        drive("sat8_fe0", 1'b1, 12'hFE0, 3'd4, 12'hFF8);
        drive("sat8_79a", 1'b1, 12'h79A, 3'd4, 12'hFFF);
        drive("dn2_123", 1'b1, 12'h123, 3'd5, 12'h001);
        drive("dn8_123", 1'b1, 12'h123, 3'd7, 12'h000);
        drive("dn4_f4a", 1'b1, 12'hF4A, 3'd6, 12'hB06);
        drive("dn8_000", 1'b1, 12'h000, 3'd7, 12'h000);
        drive("up8_fff", 1'b1, 12'hFFF, 3'd4, 12'hFFF);
        drive("dn8_f08", 1'b1, 12'hF08, 3'd7, 12'h700);

        // Back-to-back streaming through all codes with random pixels
        for (int i = 0; i < 256; i++) begin
            pix  = 12'($urandom_range(0, 4095));
            code = 3'(i % 8);
            drive("stream", 1'b1, pix, code, model(pix, code));
        end

        // Mid-stream reset overrides the register, then recovers at once
        drive("mid_reset", 1'b0, 12'h9C3, 3'd2, 12'h000);
        drive("post_reset", 1'b1, 12'h9C3, 3'd2, 12'hBE5);
        drive("post_reset2", 1'b1, 12'h3A1, 3'd6, 12'h060);

        // Exhaustive pass-through at code 0
        for (int i = 0; i < 4096; i++) begin
            pix = 12'(i);
            drive("pass_sweep", 1'b1, pix, 3'd0, pix);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
